aes_engine: RTL and testbench

AES_ENGINE -- requirements
Module: aes_engine

---
 rtl/aes_engine.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_aes_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_engine.sv
// Iterative AES-128/192/256 engine, one round per cycle.
// Round keys run on the fly; the end-of-schedule window is cached for decrypt.
module aes_engine #(
  parameter int K = 128
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           mode,
  input  logic [K-1:0]   key,
  input  logic [127:0]   din,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   dout,
  output logic           busy
);
  localparam int NK = K / 32;
  localparam int NR = NK + 6;
  localparam logic [3:0] LAST = 4'(NR);

  if (!(K == 128 || K == 192 || K == 256)) begin : g_bad_k
    $error("aes_engine: K must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {
    IDLE, FWD_EXP, CRYPT, HOLD
  } state_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), with 0 -> 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] subb(
    input logic [127:0] s,
    input logic         inv
  );
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = inv ? isbox(s[8*i +: 8]) : sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shrows(
    input logic [127:0] s,
    input logic         inv
  );
    logic [127:0] o;
    int sc;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        sc = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*sc+r) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mixcol(
    input logic [127:0] s,
    input logic         inv
  );
    logic [127:0] o;
    logic [7:0]   m [4];
    logic [7:0]   acc;
    if (inv) begin
      m[0] = 8'h0e; m[1] = 8'h0b;
      m[2] = 8'h0d; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03;
      m[2] = 8'h01; m[3] = 8'h01;
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(m[(j + 4 - r) % 4],
                           s[127-8*(4*c+j) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 1; j < 10; j++)
      if (j < n) r = xt(r);
    return r;
  endfunction

  function automatic logic [31:0] kfun(
    input logic [31:0] p,
    input int          i
  );
    logic [31:0] o;
    o = p;
    if (i % NK == 0)
      o = subw({p[23:0], p[31:24]}) ^ {rcon(i / NK), 24'h0};
    else if (NK > 6 && i % NK == 4)
      o = subw(p);
    return o;
  endfunction

  // Window holds words w[4r .. 4r+NK-1]; its first four are round key r.
  function automatic logic [K-1:0] kstep_fwd(
    input logic [K-1:0] win,
    input logic [3:0]   r
  );
    logic [31:0]  w [NK+4];
    logic [K-1:0] o;
    o = '0;
    for (int j = 0; j < NK; j++) w[j] = win[K-1-32*j -: 32];
    for (int k = 0; k < 4; k++)
      w[NK+k] = w[k] ^ kfun(w[NK+k-1], 4*int'(r) + NK + k);
    for (int j = 0; j < NK; j++) o[K-1-32*j -: 32] = w[j+4];
    return o;
  endfunction

  // Undo one step: rebuild w[4r-4 .. 4r-1] highest word first.
  function automatic logic [K-1:0] kstep_inv(
    input logic [K-1:0] win,
    input logic [3:0]   r
  );
    logic [31:0]  w [NK+4];
    logic [K-1:0] o;
    o = '0;
    for (int j = 0; j < NK; j++) w[j+4] = win[K-1-32*j -: 32];
    for (int k = 3; k >= 0; k--)
      w[k] = w[k+NK] ^ kfun(w[k+NK-1], 4*int'(r) - 4 + k + NK);
    for (int j = 0; j < NK; j++) o[K-1-32*j -: 32] = w[j];
    return o;
  endfunction

  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         mode_q, mode_d;
  logic [K-1:0] key_q, key_d;
  logic [127:0] st_q, st_d;
  logic [K-1:0] win_q, win_d;
  logic [127:0] dout_q, dout_d;
  logic [K-1:0] ck_key_q, ck_key_d;
  logic [K-1:0] ck_win_q, ck_win_d;
  logic         ck_vld_q, ck_vld_d;

  logic [3:0]   kr;
  logic [127:0] rk, t, res;
  logic [K-1:0] win_f, win_i;
  logic         hit;

  assign hit   = ck_vld_q && (ck_key_q == key);
  assign rk    = win_q[K-1 -: 128];
  assign kr    = (state_q == CRYPT && mode_q) ? LAST - rnd_q : rnd_q;
  assign win_f = kstep_fwd(win_q, kr);
  assign win_i = kstep_inv(win_q, kr);

  always_comb begin
    t   = '0;
    res = st_q ^ rk;
    if (rnd_q != 4'd0) begin
      if (!mode_q) begin
        t   = shrows(subb(st_q, 1'b0), 1'b0);
        res = ((rnd_q == LAST) ? t : mixcol(t, 1'b0)) ^ rk;
      end else begin
        t   = subb(shrows(st_q, 1'b1), 1'b1) ^ rk;
        res = (rnd_q == LAST) ? t : mixcol(t, 1'b1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    mode_d   = mode_q;
    key_d    = key_q;
    st_d     = st_q;
    win_d    = win_q;
    dout_d   = dout_q;
    ck_key_d = ck_key_q;
    ck_win_d = ck_win_q;
    ck_vld_d = ck_vld_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d = mode;
          key_d  = key;
          st_d   = din;
          rnd_d  = 4'd0;
          win_d  = key;
          state_d = CRYPT;
          if (mode && hit) win_d = ck_win_q;
          else if (mode) state_d = FWD_EXP;
        end
      end
      FWD_EXP: begin
        if (rnd_q == LAST) begin
          state_d  = CRYPT;
          rnd_d    = 4'd0;
          ck_key_d = key_q;
          ck_win_d = win_q;
          ck_vld_d = 1'b1;
        end else begin
          win_d = win_f;
          rnd_d = rnd_q + 4'd1;
        end
      end
      CRYPT: begin
        st_d = res;
        if (rnd_q == LAST) begin
          dout_d  = res;
          state_d = HOLD;
          if (!mode_q) begin
            ck_key_d = key_q;
            ck_win_d = win_q;
            ck_vld_d = 1'b1;
          end
        end else begin
          win_d = mode_q ? win_i : win_f;
          rnd_d = rnd_q + 4'd1;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rnd_q    <= '0;
      mode_q   <= 1'b0;
      key_q    <= '0;
      st_q     <= '0;
      win_q    <= '0;
      dout_q   <= '0;
      ck_key_q <= '0;
      ck_win_q <= '0;
      ck_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      mode_q   <= mode_d;
      key_q    <= key_d;
      st_q     <= st_d;
      win_q    <= win_d;
      dout_q   <= dout_d;
      ck_key_q <= ck_key_d;
      ck_win_q <= ck_win_d;
      ck_vld_q <= ck_vld_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign dout      = dout_q;
endmodule

// File: tb/tb_aes_engine.sv
// Bench for aes_engine: K=128/192/256 instances, FIPS-197 vectors,
// latency, HOLD stall, mid-block reset and key-cache behaviour.
module tb_aes_engine;
  localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KA   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [191:0] K192 =
    192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PB1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB2  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CB2  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] CZ   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid;
  logic         mode;
  logic         out_ready;
  logic [255:0] key;
  logic [127:0] din;
  logic [1:0]   sel;
  logic [2:0]   iv, ir, ov, bz;
  logic [127:0] d0, d1, d2;
  logic         i_ready, o_valid, o_busy;
  logic [127:0] o_dout;

  assign iv = in_valid ? (3'b001 << sel) : 3'b000;
  assign i_ready = ir[sel];
  assign o_valid = ov[sel];
  assign o_busy  = bz[sel];
  assign o_dout  = (sel == 2'd0) ? d0 : (sel == 2'd1) ? d1 : d2;

  aes_engine #(.K(128)) u128 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
    .mode(mode), .key(key[255:128]), .din(din), .out_valid(ov[0]),
    .out_ready(out_ready), .dout(d0), .busy(bz[0]));
  aes_engine #(.K(192)) u192 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
    .mode(mode), .key(key[255:64]), .din(din), .out_valid(ov[1]),
    .out_ready(out_ready), .dout(d1), .busy(bz[1]));
  aes_engine #(.K(256)) u256 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
    .mode(mode), .key(key), .din(din), .out_valid(ov[2]),
    .out_ready(out_ready), .dout(d2), .busy(bz[2]));

  typedef struct {
    logic [1:0]   sel;
    logic         mode;
    logic [255:0] key;
    logic [127:0] din;
    logic [127:0] exp;
    int           lat;
    int           hold;
  } vec_t;

  vec_t         vt [$];
  logic [127:0] sb [$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic scramble();
    mode = 1'($urandom_range(0, 1));
    for (int j = 0; j < 8; j++) key[32*j +: 32] = $urandom;
    for (int j = 0; j < 4; j++) din[32*j +: 32] = $urandom;
  endtask

  task automatic accept(input vec_t v);
    int n;
    sel = v.sel;
    @(negedge clk);
    mode = v.mode;
    key = v.key;
    din = v.din;
    in_valid = 1'b1;
    n = 0;
    while (!i_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chki("in_ready_before_accept", int'(i_ready), 1);
    @(posedge clk);
    #1;
    sb.push_back(v.exp);
  endtask

  task automatic run(input vec_t v);
    int n;
    logic [127:0] e;
    accept(v);
    n = 0;
    while (!o_valid && n < 100) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      scramble();
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chki("latency", n, v.lat);
    for (int h = 0; h < v.hold; h++) begin
      in_valid = 1'(h % 2 == 0);
      scramble();
      @(posedge clk);
      #1;
      chki("hold_out_valid", int'(o_valid), 1);
      chki("hold_in_ready", int'(i_ready), 0);
      chk("hold_dout", o_dout, v.exp);
    end
    in_valid = 1'b0;
    e = 128'hx;
    if (sb.size() > 0) e = sb.pop_front();
    chk("dout", o_dout, e);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chki("idle_in_ready", int'(i_ready), 1);
    chki("idle_out_valid", int'(o_valid), 0);
    if (v.hold > 0) begin
      @(posedge clk);
      #1;
      chki("idle_busy", int'(o_busy), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vec_t v;
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mode = 1'b0;
    key = '0;
    din = '0;
    sel = 2'd0;
    #2;
    chki("rst_in_ready", int'(i_ready), 1);
    chki("rst_out_valid", int'(o_valid), 0);
    chki("rst_busy", int'(o_busy), 0);
    chk("rst_dout128", d0, 128'h0);
    chk("rst_dout256", d2, 128'h0);
    @(negedge clk);
    reset = 1'b1;

    vt.push_back('{2'd0, 1'b1, {KA, 128'h0}, C128, PT0, 22, 0});
    vt.push_back('{2'd0, 1'b1, {KA, 128'h0}, C128, PT0, 11, 0});
    vt.push_back('{2'd0, 1'b0, {KA, 128'h0}, PT0, C128, 11, 5});
    vt.push_back('{2'd0, 1'b0, {KB, 128'h0}, PB1, CB1, 11, 0});
    vt.push_back('{2'd0, 1'b1, {KA, 128'h0}, C128, PT0, 22, 0});
    vt.push_back('{2'd0, 1'b1, {KB, 128'h0}, CB1, PB1, 22, 0});
    vt.push_back('{2'd0, 1'b0, 256'h0, 128'h0, CZ, 11, 0});
    vt.push_back('{2'd0, 1'b0, {KB, 128'h0}, PB2, CB2, 11, 0});
    vt.push_back('{2'd0, 1'b1, {KB, 128'h0}, CB2, PB2, 11, 0});
    vt.push_back('{2'd0, 1'b1, 256'h0, CZ, 128'h0, 22, 0});
    vt.push_back('{2'd1, 1'b1, {K192, 64'h0}, C192, PT0, 26, 0});
    vt.push_back('{2'd1, 1'b0, {K192, 64'h0}, PT0, C192, 13, 0});
    vt.push_back('{2'd1, 1'b1, {K192, 64'h0}, C192, PT0, 13, 2});
    vt.push_back('{2'd2, 1'b1, K256, C256, PT0, 30, 0});
    vt.push_back('{2'd2, 1'b0, K256, PT0, C256, 15, 0});
    vt.push_back('{2'd2, 1'b1, K256, C256, PT0, 15, 0});

    for (int i = 0; i < vt.size(); i++) run(vt[i]);

    v = '{2'd0, 1'b0, {KB, 128'h0}, PB1, CB1, 11, 0};
    run(v);
    v = '{2'd0, 1'b1, {KA, 128'h0}, C128, PT0, 22, 0};
    accept(v);
    in_valid = 1'b0;
    void'(sb.pop_back());
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chki("abort_in_ready", int'(i_ready), 1);
    chki("abort_out_valid", int'(o_valid), 0);
    chki("abort_busy", int'(o_busy), 0);
    chk("abort_dout", o_dout, 128'h0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (o_valid) n++;
    end
    chki("abort_no_out_valid", n, 0);
    run(v);
    v = '{2'd0, 1'b1, {KB, 128'h0}, CB1, PB1, 22, 0};
    run(v);
    chki("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
